// File: rtl/wb_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wb_bus_ctrl
//  Description : Sequences bridge I/O requests onto the shared 8-bit
//                Wishbone peripheral bus (UART, timer). Decodes the target,
//                strobes it until ACK or timeout, and returns one Ready
//                pulse with read data or an error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_bus_ctrl #(
  parameter int TIMEOUT = 16  // max STROBE cycles without ACK, 2..255
) (
  input  logic       PClk,
  input  logic       Reset,
  // requester side
  input  logic       Req,
  input  logic       RW,
  input  logic [4:0] Addr,
  input  logic [7:0] WData,
  output logic [7:0] RData,
  output logic       Ready,
  output logic       Err,
  // Wishbone side
  output logic [4:0] ADR_WB,
  output logic [7:0] DAT_WB,
  output logic       WE_WB,
  output logic       STB_UART,
  input  logic       ACK_UART,
  input  logic [7:0] DAT_UART,
  output logic       STB_TMR,
  input  logic       ACK_TMR,
  input  logic [7:0] DAT_TMR
);

  localparam logic [1:0] c_S_IDLE   = 2'd0;
  localparam logic [1:0] c_S_STROBE = 2'd1;
  localparam logic [1:0] c_S_DONE   = 2'd2;
  localparam logic [1:0] c_S_ERR    = 2'd3;

  // last STROBE cycle allowed before the transaction is abandoned
  localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0] r_state;
  logic [7:0] r_cnt;
  logic       r_sel_tmr;   // 0 = UART selected, 1 = timer selected
  logic [7:0] r_rdata;

  logic       w_ack;
  logic [7:0] w_dat;

  // Only the selected device's ACK/data matter; the other slave is ignored.
  assign w_ack = r_sel_tmr ? ACK_TMR : ACK_UART;
  assign w_dat = r_sel_tmr ? DAT_TMR : DAT_UART;

  // Strobes and completion flags come straight from registered state.
  assign STB_UART = (r_state == c_S_STROBE) && !r_sel_tmr;
  assign STB_TMR  = (r_state == c_S_STROBE) &&  r_sel_tmr;
  assign Ready    = (r_state == c_S_DONE) || (r_state == c_S_ERR);
  assign Err      = (r_state == c_S_ERR);
  // Error completions report zero data; the capture register itself is kept.
  assign RData    = (r_state == c_S_ERR) ? 8'h00 : r_rdata;

  // Transaction sequencer: latch request, strobe, wait for ACK or timeout.
  always_ff @(posedge PClk) begin
    if (Reset) begin
      r_state   <= c_S_IDLE;
      r_cnt     <= 8'h00;
      r_sel_tmr <= 1'b0;
      r_rdata   <= 8'h00;
      ADR_WB    <= 5'h00;
      DAT_WB    <= 8'h00;
      WE_WB     <= 1'b0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (Req) begin
            ADR_WB    <= Addr;
            DAT_WB    <= WData;
            WE_WB     <= RW;
            r_sel_tmr <= Addr[3];
            r_cnt     <= 8'h00;
            // Addr[4] is byte address bit 6: upper half of the map is empty
            r_state   <= Addr[4] ? c_S_ERR : c_S_STROBE;
          end
        end
        c_S_STROBE: begin
          // ACK takes priority over a timeout expiring in the same cycle
          if (w_ack) begin
            if (!WE_WB) begin
              r_rdata <= w_dat;
            end
            r_state <= c_S_DONE;
          end else if (r_cnt == c_TO_LAST) begin
            r_state <= c_S_ERR;
          end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'h01;
          end
        end
        c_S_DONE: r_state <= c_S_IDLE;
        c_S_ERR:  r_state <= c_S_IDLE;
        default:  r_state <= c_S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_bus_ctrl
//  Description : Self-checking bench for wb_bus_ctrl using a table of
//                directed transactions plus a reset-mid-strobe sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_bus_ctrl;

  localparam int c_TIMEOUT = 16;

  logic       PClk = 1'b0;
  logic       Reset;
  logic       Req;
  logic       RW;
  logic [4:0] Addr;
  logic [7:0] WData;
  logic [7:0] RData;
  logic       Ready;
  logic       Err;
  logic [4:0] ADR_WB;
  logic [7:0] DAT_WB;
  logic       WE_WB;
  logic       STB_UART;
  logic       ACK_UART;
  logic [7:0] DAT_UART;
  logic       STB_TMR;
  logic       ACK_TMR;
  logic [7:0] DAT_TMR;

  wb_bus_ctrl #(.TIMEOUT(c_TIMEOUT)) dut (
    .PClk     (PClk),
    .Reset    (Reset),
    .Req      (Req),
    .RW       (RW),
    .Addr     (Addr),
    .WData    (WData),
    .RData    (RData),
    .Ready    (Ready),
    .Err      (Err),
    .ADR_WB   (ADR_WB),
    .DAT_WB   (DAT_WB),
    .WE_WB    (WE_WB),
    .STB_UART (STB_UART),
    .ACK_UART (ACK_UART),
    .DAT_UART (DAT_UART),
    .STB_TMR  (STB_TMR),
    .ACK_TMR  (ACK_TMR),
    .DAT_TMR  (DAT_TMR)
  );

  always #5 PClk = ~PClk;

  // One transaction: request, slave behaviour, and expected completion.
  typedef struct {
    string      name;
    logic       rw;
    logic [4:0] addr;
    logic [7:0] wdata;
    int         ack_at;    // STB cycle on which the selected slave ACKs, 0 = never
    logic [7:0] dev_dat;   // read data returned by the selected slave
    int         spur_at;   // STB cycle on which the other slave ACKs, 0 = never
    int         exp_ready; // cycle of the Ready pulse (Req sampled at edge 0)
    logic       exp_err;
    logic [7:0] exp_rdata;
    int         exp_stbu;
    int         exp_stbt;
  } vec_t;

  vec_t vecs [8];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   stbu, stbt, rc, cur;
    logic seen, stable, err_s;
    logic [7:0] rd_s;
    logic sel_tmr;
    sel_tmr = (v.addr[4:3] == 2'b01);
    @(negedge PClk);
    Req = 1'b1; RW = v.rw; Addr = v.addr; WData = v.wdata;
    stbu = 0; stbt = 0; rc = 0; seen = 1'b0; stable = 1'b1;
    err_s = 1'b0; rd_s = 8'h00;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(posedge PClk); #1;
      ACK_UART = 1'b0; ACK_TMR = 1'b0; DAT_UART = 8'hEE; DAT_TMR = 8'hEE;
      if (STB_UART) stbu++;
      if (STB_TMR)  stbt++;
      if (STB_UART || STB_TMR) begin
        if (ADR_WB !== v.addr || WE_WB !== v.rw || DAT_WB !== v.wdata) stable = 1'b0;
        cur = STB_UART ? stbu : stbt;
        if (cur == v.ack_at) begin
          if (sel_tmr) begin ACK_TMR = 1'b1; DAT_TMR = v.dev_dat; end
          else         begin ACK_UART = 1'b1; DAT_UART = v.dev_dat; end
        end
        if (cur == v.spur_at) begin
          if (sel_tmr) begin ACK_UART = 1'b1; DAT_UART = 8'h99; end
          else         begin ACK_TMR = 1'b1; DAT_TMR = 8'h99; end
        end
      end
      if (Ready) begin
        seen = 1'b1; rc = cyc; err_s = Err; rd_s = RData;
        Req = 1'b0;
      end
    end
    if (!seen) begin
      n_vec++; n_bad++;
      $display("FAIL %s: no Ready within 40 cycles", v.name);
      Req = 1'b0;
    end else begin
      chk({v.name, " ready_cycle"}, rc, v.exp_ready);
      chk({v.name, " err"}, int'(err_s), int'(v.exp_err));
      chk({v.name, " rdata"}, int'(rd_s), int'(v.exp_rdata));
      chk({v.name, " adr_wb"}, int'(ADR_WB), int'(v.addr));
      chk({v.name, " we_wb"}, int'(WE_WB), int'(v.rw));
      chk({v.name, " dat_wb"}, int'(DAT_WB), int'(v.wdata));
    end
    chk({v.name, " stb_uart_cycles"}, stbu, v.exp_stbu);
    chk({v.name, " stb_tmr_cycles"}, stbt, v.exp_stbt);
    chk({v.name, " bus_stable"}, int'(stable), 1);
    @(posedge PClk); #1;
    chk({v.name, " ready_one_cycle"}, int'(Ready), 0);
  endtask

  initial begin
    int   stbu;
    logic seen;
    //            name      rw    addr   wdata  ack dat    spur rdy err   rdata  su  st
    vecs[0] = '{"uart_wr",  1'b1, 5'h01, 8'hA5, 1,  8'h00, 0,   2,  1'b0, 8'h00, 1,  0};
    vecs[1] = '{"tmr_rd",   1'b0, 5'h08, 8'h00, 3,  8'h3C, 2,   4,  1'b0, 8'h3C, 0,  3};
    vecs[2] = '{"uart_to",  1'b0, 5'h02, 8'h00, 0,  8'h00, 5,   17, 1'b1, 8'h00, 16, 0};
    vecs[3] = '{"uart_rd",  1'b0, 5'h03, 8'h00, 1,  8'h5A, 0,   2,  1'b0, 8'h5A, 1,  0};
    vecs[4] = '{"unmap_rd", 1'b0, 5'h10, 8'h00, 1,  8'h11, 0,   1,  1'b1, 8'h00, 0,  0};
    vecs[5] = '{"tmr_last", 1'b0, 5'h09, 8'h00, 16, 8'h77, 0,   17, 1'b0, 8'h77, 0,  16};
    vecs[6] = '{"tmr_wr",   1'b1, 5'h0F, 8'hC3, 2,  8'h22, 1,   3,  1'b0, 8'h77, 0,  2};
    vecs[7] = '{"unmap_wr", 1'b1, 5'h1F, 8'h6E, 1,  8'h00, 0,   1,  1'b1, 8'h00, 0,  0};

    Reset = 1'b1; Req = 1'b0; RW = 1'b0; Addr = 5'h00; WData = 8'h00;
    ACK_UART = 1'b0; ACK_TMR = 1'b0; DAT_UART = 8'h00; DAT_TMR = 8'h00;
    repeat (3) @(posedge PClk);
    #1;
    chk("rst stb_uart", int'(STB_UART), 0);
    chk("rst stb_tmr", int'(STB_TMR), 0);
    chk("rst ready", int'(Ready), 0);
    chk("rst err", int'(Err), 0);
    chk("rst we_wb", int'(WE_WB), 0);
    chk("rst adr_wb", int'(ADR_WB), 0);
    chk("rst dat_wb", int'(DAT_WB), 0);
    chk("rst rdata", int'(RData), 0);
    Reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset during the 2nd STB cycle of a UART write, Req kept high throughout.
    @(negedge PClk);
    Req = 1'b1; RW = 1'b1; Addr = 5'h04; WData = 8'h81;
    @(posedge PClk); #1;
    chk("rst_mid stb_c1", int'(STB_UART), 1);
    @(posedge PClk); #1;
    chk("rst_mid stb_c2", int'(STB_UART), 1);
    Reset = 1'b1;
    @(posedge PClk); #1;
    chk("rst_mid stb_after", int'(STB_UART), 0);
    chk("rst_mid ready", int'(Ready), 0);
    chk("rst_mid err", int'(Err), 0);
    chk("rst_mid adr_wb", int'(ADR_WB), 0);
    chk("rst_mid dat_wb", int'(DAT_WB), 0);
    chk("rst_mid we_wb", int'(WE_WB), 0);
    chk("rst_mid rdata", int'(RData), 0);
    Reset = 1'b0;
    // fresh transaction from IDLE: STROBE in the cycle after reset releases
    stbu = 0; seen = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(posedge PClk); #1;
      ACK_UART = 1'b0;
      if (STB_UART) begin
        stbu++;
        if (stbu == 1) begin
          chk("rst_mid restart_cycle", cyc, 1);
          chk("rst_mid restart_adr", int'(ADR_WB), 5'h04);
          chk("rst_mid restart_dat", int'(DAT_WB), 8'h81);
        end
        if (stbu == 2) ACK_UART = 1'b1;
      end
      if (Ready) begin
        seen = 1'b1;
        Req = 1'b0;
        chk("rst_mid restart_ready_cycle", cyc, 3);
        chk("rst_mid restart_err", int'(Err), 0);
      end
    end
    if (!seen) begin
      n_vec++; n_bad++;
      $display("FAIL rst_mid restart: no Ready within 40 cycles");
    end
    Req = 1'b0;
    @(posedge PClk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_bus_ctrl.md
# wb_bus_ctrl

Wishbone-side bus controller that sequences processor-bus I/O accesses onto the 8-bit peripheral bus shared by the UART and the timer. It sits between the processor/bridge I/O request port and the two Wishbone slaves. It decodes the target device, drives a single strobed transaction, and waits for the device ACK with a timeout. It then returns one Ready pulse, plus read data or an error flag, to the requester.

## Interface
- TIMEOUT, 16, max STROBE cycles without ACK before abort; legal range 2..255
- PClk  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Req  in  1  I/O request from bridge; held high until Ready
- RW  in  1  1 = write, 0 = read; sampled with Req
- Addr  in  5  word address [6:2]; [6:5] = 00 UART, 01 timer, 1x unmapped
- WData  in  8  write data, sampled with Req
- RData  out  8  read data, valid only while Ready=1 and Err=0
- Ready  out  1  one-cycle completion pulse
- Err  out  1  qualifies Ready: unmapped address or timeout
- ADR_WB  out  5  Wishbone address [6:2]
- DAT_WB  out  8  Wishbone write data
- WE_WB  out  1  Wishbone write enable
- STB_UART  out  1  strobe to UART
- ACK_UART  in  1  UART acknowledge
- DAT_UART  in  8  UART read data
- STB_TMR  out  1  strobe to timer
- ACK_TMR  in  1  timer acknowledge
- DAT_TMR  in  8  timer read data

## Operation
States and transitions:
- IDLE
  - Req=1 with Addr[6] set: latch Addr, RW, WData; go to ERR.
  - Req=1 with a mapped address: latch Addr, RW, WData; latch select (UART or timer); clear timeout counter; go to STROBE.
- STROBE
  - Asserts the selected STB only. The other device's STB stays 0.
  - ADR_WB, DAT_WB and WE_WB are driven from the latched values and stay stable for the whole state.
  - Selected ACK=1: capture the selected device's data (reads) into the RData register; go to DONE.
  - ACK=0: increment the counter. When counter = TIMEOUT-1 and ACK is still 0, go to ERR.
- DONE: Ready=1, Err=0; go to IDLE.
- ERR: Ready=1, Err=1, RData=0; go to IDLE.

Rules:
- ACK from the non-selected device is ignored in every state.
- ACK in IDLE, DONE or ERR is ignored.
- Req is only sampled in IDLE. Req held high through DONE/ERR is not a new request.
- A new request is accepted no earlier than the IDLE cycle that follows Ready.
- Writes: RData is don't-care but holds its last value; it is not cleared.
- If ACK and timeout expiry coincide in the same cycle, ACK wins and the state goes to DONE.
- The counter is 8 bits wide and saturates; it never wraps.
- Reset in any state, including mid-STROBE:
  - Next state is IDLE.
  - All STB drop at the next edge.
  - The pending transaction is discarded with no Ready.

## Timing
- STB, Ready and Err are decoded from registered state, so they change only after PClk edges.
- ADR_WB, DAT_WB and WE_WB are registers.
- Reset values:
  - State IDLE, counter 0.
  - STB_UART=0, STB_TMR=0, WE_WB=0.
  - ADR_WB=0, DAT_WB=0, RData=0.
  - Ready=0, Err=0.
- Latency, with Req sampled at edge 0:
  - STROBE occupies cycle 1.
  - ACK in cycle 1 → DONE in cycle 2 (Ready after 2 edges).
  - ACK in STROBE cycle k → Ready in cycle k+1.
  - Unmapped address: ERR in cycle 1.
  - No ACK: ERR in cycle TIMEOUT+1. STB is high for exactly TIMEOUT cycles.
- Back-to-back: minimum period per transaction is 3 cycles (IDLE, STROBE, DONE).

## Test plan
- UART write: Req=1, RW=1, Addr=5'h01, WData=8'hA5; UART ACKs on the 1st STB cycle → WE_WB=1, ADR_WB=5'h01, DAT_WB=8'hA5; STB_UART high 1 cycle, STB_TMR=0; Ready=1, Err=0 exactly 2 cycles after Req sampled.
- Timer read with wait: Addr=5'h08, RW=0; ACK_TMR after 3 STB cycles with DAT_TMR=8'h3C → RData=8'h3C, Ready in the cycle after ACK; an ACK_UART pulse mid-transaction is ignored.
- Timeout: TIMEOUT=16, UART never ACKs → STB_UART high for 16 cycles, then Ready=1, Err=1, RData=0; next request then completes normally.
- Unmapped: Addr=5'h10 → no STB asserted, Ready=1, Err=1 in cycle 1.
- ACK on the final timeout cycle → DONE, Err=0.
- Reset mid-STROBE: assert Reset during the 2nd STB cycle → STB low after that edge, no Ready pulse, all outputs at reset values; Req held high afterwards starts a fresh transaction from IDLE.
